gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
Self-checking stimulus/response stage wrapped around logic_gates_dataflow. Sequences all four (a,b) input combinations into the gate block and samples its seven outputs after a programmable settle time. Compares each output against the expected truth table and reports error count, first-failure info and a final pass flag. Gives synthesizable on-board/regression checking in place of a $monitor-only bench.

Parameters:
SETTLE_CYCLES, 2, cycles waited after driving a/b before sampling; 0 allowed (no wait)
NUM_PASSES, 1, number of full 4-vector sweeps per run; must be >=1
ERR_W, 4, width of err_count (saturating)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE or DONE
a  output  1  stimulus to gate block, registered
b  output  1  stimulus to gate block, registered
and_g  input  1  gate block AND result
or_g  input  1  gate block OR result
not_g_a  input  1  gate block NOT(a) result
nand_g  input  1  gate block NAND result
nor_g  input  1  gate block NOR result
xor_g  input  1  gate block XOR result
xnor_g  input  1  gate block XNOR result
busy  output  1  high from the cycle after start is accepted until done rises
done  output  1  high in DONE, held until next accepted start or reset
pass  output  1  valid when done=1: 1 iff err_count==0; 0 otherwise
err_count  output  ERR_W  mismatching vectors counted, saturates at 2^ERR_W-1
fail_vec  output  2  {a,b} of first mismatching vector
fail_mask  output  7  XOR of observed vs expected at first mismatch; bit6..0 = and,or,not,nand,nor,xor,xnor

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset (any state, incl. mid-sweep): state=IDLE; a=b=0; busy=done=pass=0; err_count=0; fail_vec=0; fail_mask=0; internal vector and pass counters=0.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1: clear err_count, fail_vec, fail_mask, pass, done, vector counter vec=0, pass counter=0, first-fail flag; go DRIVE; busy=1.
- start ignored in DRIVE/SETTLE/CHECK.
- DRIVE (1 cycle): a<=vec[1], b<=vec[0]; load settle counter with SETTLE_CYCLES; go SETTLE, or CHECK directly if SETTLE_CYCLES==0.
- SETTLE: decrement each cycle; exit to CHECK when counter reaches 0 (exactly SETTLE_CYCLES cycles in state).
- CHECK (1 cycle): expected from registered a,b: and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b). diff = observed ^ expected (7 bits).
  - diff!=0: err_count+1 (saturating, hold at max). If no prior failure this run: fail_vec<={a,b}, fail_mask<=diff, set first-fail flag. Later failures never overwrite.
  - vec==3 and pass counter==NUM_PASSES-1: go DONE. vec==3 otherwise: vec<=0, pass counter+1, go DRIVE. Else vec+1, go DRIVE.
- DONE: done=1, busy=0, pass=(err_count==0); a,b hold last vector.
- Per-vector cost SETTLE_CYCLES+2 cycles. done first high exactly 4*NUM_PASSES*(SETTLE_CYCLES+2)+1 rising edges after the edge that sampled start (default: 17).
- Vector order fixed: 00,01,10,11.
- Outputs counted once per vector per pass (not per bit).

Test Plan:
- Correct gate block, defaults, 1-cycle start pulse -> a,b step 00,01,10,11; done at edge 17; pass=1, err_count=0, fail_mask=0.
- and_g forced 0 -> err_count=1, fail_vec=2'b11, fail_mask=7'b1000000, pass=0.
- xnor_g tied to xor_g -> err_count=4, fail_vec=2'b00, fail_mask=7'b0000001.
- ERR_W=2, NUM_PASSES=2, all seven inputs inverted -> err_count saturates at 3, fail_vec=00, fail_mask=7'h7F.
- SETTLE_CYCLES=0 -> done at edge 9; start pulsed while busy -> no restart, timing unchanged.
- rst asserted during SETTLE of vector 2 -> next cycle all outputs reset values, state IDLE; fresh start completes normally with pass=1; start from DONE clears done the following cycle.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Purpose : drives all four (a,b) combinations into a 7-output gate block, checks each result.
// Latency : done rises 4*NUM_PASSES*(SETTLE_CYCLES+2)+1 clocks after the clock that samples start.
// Backpress: none; start is a level sampled only in IDLE/DONE, ignored while a run is in flight.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 begin a run (accepted in IDLE or DONE only)
//   a, b                  registered stimulus to the gate block
//   and_g .. xnor_g       observed gate block outputs
//   busy, done, pass      run status; pass is meaningful while done=1
//   err_count             mismatching vectors, saturating
//   fail_vec, fail_mask   {a,b} and observed^expected of the first mismatching vector
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             and_g,
    input  logic             or_g,
    input  logic             not_g_a,
    input  logic             nand_g,
    input  logic             nor_g,
    input  logic             xor_g,
    input  logic             xnor_g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_vec,
    output logic [6:0]       fail_mask
);

    // Counter widths never collapse to zero, even for NUM_PASSES=1 or SETTLE_CYCLES<=1.
    localparam int PCNT_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int SC_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]        state;
    logic [1:0]        vec;
    logic [PCNT_W-1:0] pass_cnt;
    logic [SC_W-1:0]   settle_cnt;
    logic              first_fail_seen;

    logic [6:0] observed;
    logic [6:0] expected;
    logic [6:0] diff;
    logic       last_vec;
    logic       last_pass;
    logic       err_sat;

    // Expected values come from the registered stimulus, which is what the
    // gate block has actually been looking at since DRIVE.
    always_comb begin
        observed  = {and_g, or_g, not_g_a, nand_g, nor_g, xor_g, xnor_g};
        expected  = {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
        diff      = observed ^ expected;
        last_vec  = (vec == 2'd3);
        last_pass = (pass_cnt == PCNT_W'(NUM_PASSES - 1));
        err_sat   = &err_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            a               <= 1'b0;
            b               <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            fail_vec        <= 2'd0;
            fail_mask       <= 7'd0;
            vec             <= 2'd0;
            pass_cnt        <= '0;
            settle_cnt      <= '0;
            first_fail_seen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // done/pass are published one clock after entering DONE.
                    if (state == ST_DONE) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        pass <= (err_count == '0);
                    end
                    // A new start wins over the DONE bookkeeping above.
                    if (start) begin
                        err_count       <= '0;
                        fail_vec        <= 2'd0;
                        fail_mask       <= 7'd0;
                        pass            <= 1'b0;
                        done            <= 1'b0;
                        busy            <= 1'b1;
                        vec             <= 2'd0;
                        pass_cnt        <= '0;
                        first_fail_seen <= 1'b0;
                        state           <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    a          <= vec[1];
                    b          <= vec[0];
                    settle_cnt <= SC_W'(SETTLE_CYCLES);
                    state      <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
                end

                ST_SETTLE: begin
                    // Leaving when the count is 1 gives exactly SETTLE_CYCLES clocks here.
                    settle_cnt <= settle_cnt - SC_W'(1);
                    if (settle_cnt == SC_W'(1)) begin
                        state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (diff != 7'd0) begin
                        if (!err_sat) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (!first_fail_seen) begin
                            fail_vec        <= {a, b};
                            fail_mask       <= diff;
                            first_fail_seen <= 1'b1;
                        end
                    end
                    if (last_vec && last_pass) begin
                        state <= ST_DONE;
                    end else if (last_vec) begin
                        vec      <= 2'd0;
                        pass_cnt <= pass_cnt + PCNT_W'(1);
                        state    <= ST_DRIVE;
                    end else begin
                        vec   <= vec + 2'd1;
                        state <= ST_DRIVE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances with different parameter sets,
// each wrapped around a gate-block model whose outputs can be corrupted per input vector.
// Expected results come from fixed vectors and from a sweep-level reference model.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int LIMIT = 300;

    int checks = 0;
    int errors = 0;

    // Per-instance stimulus and fault masks (indexed by {a,b}).
    logic start0 = 0, start1 = 0, start2 = 0;
    logic rst0 = 1, rst1 = 1, rst2 = 1;
    logic [3:0][6:0] fm0 = '0, fm1 = '0, fm2 = '0;

    logic a0, b0, busy0, done0, pass0;
    logic a1, b1, busy1, done1, pass1;
    logic a2, b2, busy2, done2, pass2;
    logic [3:0] ec0, ec1;
    logic [1:0] ec2;
    logic [1:0] fv0, fv1, fv2;
    logic [6:0] fk0, fk1, fk2;
    logic [6:0] g0, g1, g2;

    // Gate block truth table with an injected per-vector corruption mask.
    function automatic logic [6:0] gate(input logic ia, input logic ib, input logic [3:0][6:0] m);
        logic [6:0] good;
        good = {ia & ib, ia | ib, ~ia, ~(ia & ib), ~(ia | ib), ia ^ ib, ~(ia ^ ib)};
        return good ^ m[{ia, ib}];
    endfunction

    always_comb begin
        g0 = gate(a0, b0, fm0);
        g1 = gate(a1, b1, fm1);
        g2 = gate(a2, b2, fm2);
    end

    gate_sweep_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .ERR_W(4)) u0 (
        .clk(clk), .rst(rst0), .start(start0), .a(a0), .b(b0),
        .and_g(g0[6]), .or_g(g0[5]), .not_g_a(g0[4]), .nand_g(g0[3]),
        .nor_g(g0[2]), .xor_g(g0[1]), .xnor_g(g0[0]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
        .fail_vec(fv0), .fail_mask(fk0));

    gate_sweep_checker #(.SETTLE_CYCLES(0), .NUM_PASSES(1), .ERR_W(4)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .and_g(g1[6]), .or_g(g1[5]), .not_g_a(g1[4]), .nand_g(g1[3]),
        .nor_g(g1[2]), .xor_g(g1[1]), .xnor_g(g1[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
        .fail_vec(fv1), .fail_mask(fk1));

    gate_sweep_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .ERR_W(2)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2),
        .and_g(g2[6]), .or_g(g2[5]), .not_g_a(g2[4]), .nand_g(g2[3]),
        .nor_g(g2[2]), .xor_g(g2[1]), .xnor_g(g2[0]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2),
        .fail_vec(fv2), .fail_mask(fk2));

    function automatic int settle_of(input int i);
        return (i == 1) ? 0 : 2;
    endfunction
    function automatic int passes_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int errmax_of(input int i);
        return (i == 2) ? 3 : 15;
    endfunction

    // Status word: a b busy done pass err[3:0] fail_vec[1:0] fail_mask[6:0]
    function automatic logic [17:0] st(input int i);
        case (i)
            0:       return {a0, b0, busy0, done0, pass0, ec0, fv0, fk0};
            1:       return {a1, b1, busy1, done1, pass1, ec1, fv1, fk1};
            default: return {a2, b2, busy2, done2, pass2, {2'b00, ec2}, fv2, fk2};
        endcase
    endfunction

    task automatic set_start(input int i, input logic v);
        case (i)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic set_mask(input int i, input logic [3:0][6:0] m);
        case (i)
            0:       fm0 = m;
            1:       fm1 = m;
            default: fm2 = m;
        endcase
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: walk the sweeps as lists of vectors and count the corrupted ones.
    task automatic model(input int i, input logic [3:0][6:0] m,
                         output int e_err, output int e_vec, output int e_mask, output int e_pass);
        int seen;
        e_err = 0; e_vec = 0; e_mask = 0; seen = 0;
        for (int p = 0; p < passes_of(i); p++) begin
            for (int v = 0; v < 4; v++) begin
                if (m[v] != 7'd0) begin
                    if (e_err < errmax_of(i)) e_err++;
                    if (seen == 0) begin
                        seen   = 1;
                        e_vec  = v;
                        e_mask = int'(m[v]);
                    end
                end
            end
        end
        e_pass = (e_err == 0) ? 1 : 0;
    endtask

    // One full run: start pulse, a stray start while busy, stimulus order,
    // done latency and final results.
    task automatic run(input int i, input logic [3:0][6:0] m, input int e_err,
                       input int e_vec, input int e_mask, input int e_pass, input string nm);
        logic [17:0] s;
        int n;
        int s_cyc;
        int lat;
        s_cyc = settle_of(i);
        lat   = 4 * passes_of(i) * (s_cyc + 2) + 1;
        set_mask(i, m);
        @(posedge clk); #1 set_start(i, 1'b1);
        @(posedge clk); #1 set_start(i, 1'b0);
        s = st(i);
        chk({nm, "_busy_done_after_start"}, int'({s[15], s[14]}), 2);
        n = 0;
        while (!s[14] && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) set_start(i, 1'b1);
            if (n == 4) set_start(i, 1'b0);
            s = st(i);
            for (int k = 0; k < 4; k++) begin
                if (n == 1 + k * (s_cyc + 2)) chk({nm, "_ab_order"}, int'({s[17], s[16]}), k);
            end
        end
        chk({nm, "_done_latency"}, n, lat);
        chk({nm, "_busy_at_done"}, int'(s[15]), 0);
        chk({nm, "_err_count"}, int'(s[12:9]), e_err);
        chk({nm, "_fail_vec"}, int'(s[8:7]), e_vec);
        chk({nm, "_fail_mask"}, int'(s[6:0]), e_mask);
        chk({nm, "_pass"}, int'(s[13]), e_pass);
    endtask

    typedef struct {
        int              inst;
        logic [3:0][6:0] m;
        int              e_err;
        int              e_vec;
        int              e_mask;
        int              e_pass;
        string           nm;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [17:0] s;
        logic [3:0][6:0] m;
        int e_err, e_vec, e_mask, e_pass, inst;

        tbl[0] = '{0, '0,                          0, 0, 7'h00, 1, "clean"};
        tbl[1] = '{0, {7'h40, 7'h00, 7'h00, 7'h00}, 1, 3, 7'h40, 0, "and_stuck0"};
        tbl[2] = '{0, {7'h01, 7'h01, 7'h01, 7'h01}, 4, 0, 7'h01, 0, "xnor_is_xor"};
        tbl[3] = '{2, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 3, 0, 7'h7F, 0, "all_inv_sat"};
        tbl[4] = '{1, '0,                          0, 0, 7'h00, 1, "settle0"};
        tbl[5] = '{0, {7'h00, 7'h22, 7'h15, 7'h00}, 2, 1, 7'h15, 0, "two_faults"};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("reset_state", int'(st(i)), 0);
        rst0 = 0; rst1 = 0; rst2 = 0;

        for (int t = 0; t < 6; t++)
            run(tbl[t].inst, tbl[t].m, tbl[t].e_err, tbl[t].e_vec, tbl[t].e_mask, tbl[t].e_pass, tbl[t].nm);

        // done and results hold while idle in DONE
        repeat (3) @(posedge clk);
        #1 s = st(0);
        chk("done_held", int'({s[14], s[13], s[12:9]}), 6'b10_0010);

        // Reset during SETTLE of vector 2, after two faulty vectors were counted.
        set_mask(0, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        @(posedge clk); #1 start0 = 1;
        @(posedge clk); #1 start0 = 0;
        repeat (9) @(posedge clk);
        #1 s = st(0);
        chk("pre_reset_ab", int'({s[17], s[16]}), 2);
        chk("pre_reset_err", int'(s[12:9]), 2);
        rst0 = 1;
        @(posedge clk); #1 rst0 = 0;
        chk("mid_run_reset", int'(st(0)), 0);
        run(0, '0, 0, 0, 0, 1, "after_reset");

        // Randomized corruption patterns against the sweep-level model.
        for (int r = 0; r < 12; r++) begin
            inst = $urandom_range(0, 2);
            for (int v = 0; v < 4; v++)
                m[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
            model(inst, m, e_err, e_vec, e_mask, e_pass);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run(inst, m, e_err, e_vec, e_mask, e_pass, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
